// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared constants for the streaming CRC engine.
// It holds the common generator polynomials (with the implicit top term
// omitted), the FSM state encoding, and the state enum built on that encoding.
// ---------------------------------------------------------------------------
package crc_pkg;

    localparam logic [11:0] CRC12_POLY  = 12'h80F;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] CRC32_POLY  = 32'h04C11DB7;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ACCUM = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM
    } crc_state_t;

endpackage

// File: rtl/crc_step_comb.sv
// ---------------------------------------------------------------------------
// crc_step_comb
// Combinational fold of one DATA_W-bit beat into a CRC_W-bit CRC.
// The beat is processed MSB first, one chained bit step per data bit.
// Ports:
//   crc_in   in   CRC_W   running CRC before this beat
//   data_in  in   DATA_W  beat to fold in
//   crc_out  out  CRC_W   running CRC after this beat
// ---------------------------------------------------------------------------
module crc_step_comb
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 12,
    parameter logic [CRC_W-1:0] POLY   = CRC12_POLY,
    parameter int               DATA_W = 32
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);

    always_comb begin
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = crc_in;
        fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ data_in[i];
            crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_out = crc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// ---------------------------------------------------------------------------
// crc_stream_engine
// Streaming CRC engine. It folds one DATA_W-bit beat per clock into a running
// CRC and presents one CRC_W-bit result per frame through a one-entry output
// register.
// Optional build macro: CRC_REFLECT_EN. When it is defined, each byte of
// s_data is bit-reversed before it is folded in, and the final CRC is
// bit-reversed before XOR_OUT is applied. This gives the reflected
// (LSB-first) CRC convention.
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   s_valid    in   1       input beat valid
//   s_ready    out  1       beat can be accepted this cycle
//   s_data     in   DATA_W  input beat, MSB first
//   s_last     in   1       final beat of the frame
//   m_valid    out  1       m_crc holds a finished result
//   m_ready    in   1       downstream consumes the result
//   m_crc      out  CRC_W   finished CRC (after XOR_OUT)
//   busy       out  1       frame partially accumulated
//   frame_cnt  out  CNT_W   results consumed, wrapping
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no beat of the current frame accepted yet
// ACCUM | mid-frame, crc_q holds a partial CRC
// ---------------------------------------------------------------------------
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 12,
    parameter logic [CRC_W-1:0] POLY    = CRC12_POLY,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter int               DATA_W  = 32,
    parameter int               CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  m_crc,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    crc_state_t        state;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  step_out;
    logic [CRC_W-1:0]  final_crc;
    logic [DATA_W-1:0] step_data;
    logic              accept;

    // A pending result that is being consumed this cycle frees the register,
    // so a new last beat can land on the same edge without a bubble.
    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

`ifdef CRC_REFLECT_EN
    always_comb begin
        step_data = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            for (int k = 0; k < 8; k++) begin
                step_data[b*8+k] = s_data[b*8+7-k];
            end
        end
    end

    always_comb begin
        logic [CRC_W-1:0] rev;
        rev = '0;
        for (int k = 0; k < CRC_W; k++) begin
            rev[k] = step_out[CRC_W-1-k];
        end
        final_crc = rev ^ XOR_OUT;
    end
`else
    assign step_data = s_data;
    assign final_crc = step_out ^ XOR_OUT;
`endif

    crc_step_comb #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_step (
        .crc_in  (crc_q),
        .data_in (step_data),
        .crc_out (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            crc_q     <= INIT;
            m_valid   <= 1'b0;
            m_crc     <= '0;
            frame_cnt <= '0;
        end else begin
            if (m_valid && m_ready) begin
                frame_cnt <= frame_cnt + 1'b1;
                m_valid   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && !s_last) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept && s_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (accept) begin
                if (s_last) begin
                    // A last beat overrides the clear above on the same edge.
                    m_crc   <= final_crc;
                    m_valid <= 1'b1;
                    crc_q   <= INIT;
                end else begin
                    crc_q   <= step_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
module tb_crc_stream_engine;

    localparam logic [11:0] POLY = 12'h80F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [11:0] m_crc;
    logic        busy;
    logic [15:0] frame_cnt;

    logic        w_valid = 1'b0;
    logic        w_s_ready;
    logic        w_m_valid;
    logic        w_m_ready = 1'b0;
    logic [11:0] w_crc;
    logic        w_busy;
    logic [1:0]  w_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crc_stream_engine dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_crc     (m_crc),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    crc_stream_engine #(.CNT_W(2)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (w_valid),
        .s_ready   (w_s_ready),
        .s_data    (32'h0000_0001),
        .s_last    (1'b1),
        .m_valid   (w_m_valid),
        .m_ready   (w_m_ready),
        .m_crc     (w_crc),
        .busy      (w_busy),
        .frame_cnt (w_cnt)
    );

    // Bit-serial reference: walk the frame byte by byte, most significant byte first.
    function automatic logic [11:0] model(input logic [31:0] words[$]);
        logic [11:0] crc;
        logic [11:0] rev;
        logic [7:0]  byt;
        logic        bitv;
        logic        fb;
        crc = 12'h000;
        foreach (words[w]) begin
            for (int b = 3; b >= 0; b--) begin
                byt = words[w][b*8 +: 8];
                for (int k = 0; k < 8; k++) begin
`ifdef CRC_REFLECT_EN
                    bitv = byt[k];
`else
                    bitv = byt[7-k];
`endif
                    fb  = crc[11] ^ bitv;
                    crc = {crc[10:0], 1'b0} ^ (fb ? POLY : 12'h000);
                end
            end
        end
`ifdef CRC_REFLECT_EN
        for (int k = 0; k < 12; k++) rev[k] = crc[11-k];
        crc = rev;
`else
        rev = crc;
`endif
        return crc;
    endfunction

    // Directed tests use the documented constants for the plain build and the model otherwise.
    function automatic logic [11:0] dir_exp(input logic [31:0] words[$], input logic [11:0] konst);
`ifdef CRC_REFLECT_EN
        return model(words);
`else
        return konst;
`endif
    endfunction

    task automatic do_reset();
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        w_valid   = 1'b0;
        w_m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL beat_accept: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (m_valid !== 1'b0)     begin bad++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        total++; if (m_crc !== 12'h000)    begin bad++; $display("FAIL reset_m_crc: got %h want 000", m_crc); end
        total++; if (frame_cnt !== 16'd0)  begin bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (s_ready !== 1'b1)     begin bad++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
    endtask

    task automatic test_single_beat();
        logic [31:0] d[3];
        logic [11:0] k[3];
        logic [31:0] q[$];
        logic [11:0] e;
        d[0] = 32'h0000_0000; k[0] = 12'h000;
        d[1] = 32'h0000_0001; k[1] = 12'h80F;
        d[2] = 32'h0000_0002; k[2] = 12'h811;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(d[i], 1'b1);
            q.delete();
            q.push_back(d[i]);
            e = dir_exp(q, k[i]);
            total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_valid[%0d]: got %0b want 1", i, m_valid); end
            total++; if (m_crc !== e)      begin bad++; $display("FAIL single_crc[%0d]: got %h want %h", i, m_crc, e); end
        end
    endtask

    task automatic test_two_beat();
        logic [31:0] q[$];
        logic [11:0] e;
        do_reset();
        q.push_back(32'h0000_0000);
        q.push_back(32'h0000_0001);
        e = dir_exp(q, 12'h80F);
        beat(32'h0000_0000, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL two_busy: got %0b want 1", busy); end
        beat(32'h0000_0001, 1'b1);
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL two_busy_end: got %0b want 0", busy); end
        total++; if (m_crc !== e)      begin bad++; $display("FAIL two_crc: got %h want %h", m_crc, e); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL two_cnt_before: got %0d want 0", frame_cnt); end
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL two_cnt_after: got %0d want 1", frame_cnt); end
        total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL two_valid_after: got %0b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] q[$];
        logic [11:0] e0;
        logic [11:0] e1;
        do_reset();
        q.push_back(32'h0000_0002);
        e0 = dir_exp(q, 12'h811);
        q.delete();
        q.push_back(32'h0000_0001);
        e1 = dir_exp(q, 12'h80F);
        beat(32'h0000_0002, 1'b1);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'h0000_0001;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL hold_s_ready[%0d]: got %0b want 0", i, s_ready); end
            total++; if (m_crc !== e0 || m_valid !== 1'b1) begin bad++; $display("FAIL hold_crc[%0d]: got %h/%0b want %h/1", i, m_crc, m_valid, e0); end
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        total++; if (m_valid !== 1'b1 || m_crc !== e1) begin bad++; $display("FAIL release_crc: got %h/%0b want %h/1", m_crc, m_valid, e1); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL release_cnt: got %0d want 1", frame_cnt); end
        @(posedge clk);
        #1;
        total++; if (m_valid !== 1'b0 || frame_cnt !== 16'd2) begin bad++; $display("FAIL release_drain: got %0b/%0d want 0/2", m_valid, frame_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d[4];
        logic [11:0] e[4];
        logic [31:0] q[$];
        logic [15:0] c0;
        d[0] = 32'h0000_0003; d[1] = 32'hDEAD_BEEF; d[2] = 32'h0000_0001; d[3] = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            q.delete();
            q.push_back(d[i]);
            e[i] = model(q);
        end
        m_ready = 1'b1;
        @(negedge clk);
        c0 = frame_cnt;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                total++; if (m_valid !== 1'b1 || m_crc !== e[i-1]) begin bad++; $display("FAIL b2b[%0d]: got %h/%0b want %h/1", i-1, m_crc, m_valid, e[i-1]); end
            end
            if (i < 4) begin
                s_valid = 1'b1;
                s_data  = d[i];
                s_last  = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (frame_cnt !== c0 + 16'd4) begin bad++; $display("FAIL b2b_cnt: got %0d want %0d", frame_cnt, c0 + 16'd4); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] q[$];
        logic [11:0] e;
        m_ready = 1'b1;
        beat(32'h0000_0005, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0)
            begin bad++; $display("FAIL mid_reset: got valid=%0b busy=%0b cnt=%0d want 0/0/0", m_valid, busy, frame_cnt); end
        @(negedge clk);
        rst = 1'b0;
        q.push_back(32'h0000_0001);
        e = dir_exp(q, 12'h80F);
        beat(32'h0000_0001, 1'b1);
        total++; if (m_crc !== e || m_valid !== 1'b1) begin bad++; $display("FAIL mid_next_crc: got %h/%0b want %h/1", m_crc, m_valid, e); end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        w_valid   = 1'b1;
        w_m_ready = 1'b1;
        repeat (5) @(negedge clk);
        w_valid = 1'b0;
        @(negedge clk);
        total++; if (w_cnt !== 2'd1) begin bad++; $display("FAIL wrap_cnt: got %0d want 1", w_cnt); end
        w_m_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] frame[$];
        logic [11:0] expq[$];
        logic [11:0] e;
        logic [31:0] cur_d;
        logic        cur_l;
        logic        have;
        int          remaining;
        int          sent;
        int          got;
        int          cycles;
        do_reset();
        have = 1'b0; remaining = 0; sent = 0; got = 0; cycles = 0;
        cur_d = '0; cur_l = 1'b0;
        while (got < 1000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            if (!have && sent < 1000) begin
                if (remaining == 0) remaining = $urandom_range(1, 8);
                cur_d = $urandom;
                cur_l = (remaining == 1);
                have  = 1'b1;
            end
            s_valid = have && ($urandom_range(0, 3) != 0);
            s_data  = cur_d;
            s_last  = cur_l;
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (m_valid && m_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL rand_unexpected: got result %h want none", m_crc);
                end else begin
                    e = expq.pop_front();
                    if (m_crc !== e) begin bad++; $display("FAIL rand_crc[%0d]: got %h want %h", got, m_crc, e); end
                end
                got++;
            end
            if (s_valid && s_ready) begin
                frame.push_back(cur_d);
                remaining--;
                have = 1'b0;
                if (cur_l) begin
                    expq.push_back(model(frame));
                    frame.delete();
                    sent++;
                end
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        total++; if (got != 1000) begin bad++; $display("FAIL rand_count: got %0d results want 1000", got); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
